spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: TX/RX byte FIFOs around a chip-select framing FSM driving a byte engine.
// Optional RX path is enabled by defining SPI_XFER_RX_FIFO_EN; without it received bytes are dropped.
module spi_xfer_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  // TX push stream
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  // RX pop stream
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  // Byte engine
  output logic       byte_start,
  output logic [7:0] byte_data,
  input  logic       byte_busy,
  input  logic       byte_done,
  input  logic [7:0] byte_rx,
  // Framing / status
  output logic       cs_n,
  output logic       frame_done,
  output logic       rx_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] SetupLast = (SETUP_CYC > 0) ? CW'(SETUP_CYC - 1) : '0;
  localparam logic [CW-1:0] HoldLast  = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLaunch,
    StWait,
    StStall,
    StHold
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          frame_done_q, frame_done_d;
  logic          rx_push_req;

  // ---------------------------------------------------------------------------
  // TX FIFO: entries are {last, data}; the extra pointer bit separates full from empty
  // ---------------------------------------------------------------------------
  logic [8:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW:0] tx_wptr_q, tx_wptr_d;
  logic [AW:0] tx_rptr_q, tx_rptr_d;
  logic        tx_empty, tx_full, tx_push, tx_pop;
  logic [8:0]  tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = byte_start;
  assign tx_head  = tx_mem_q[tx_rptr_q[AW-1:0]];

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= {tx_last, tx_data};
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    byte_start   = 1'b0;
    rx_push_req  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty) begin
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q >= SetupLast) state_d = StLaunch;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      StLaunch: begin
        // tx_empty guard is defensive: only this FSM pops, so LAUNCH implies data
        if (!byte_busy && !tx_empty) begin
          byte_start = 1'b1;
          last_d     = tx_head[8];
          state_d    = StWait;
        end
      end
      StWait: begin
        if (byte_done) begin
          rx_push_req = 1'b1;
          if (last_q) begin
            state_d = StHold;
            cnt_d   = '0;
          end else if (!tx_empty) begin
            state_d = StLaunch;
          end else begin
            state_d = StStall;
          end
        end
      end
      StStall: begin
        if (!tx_empty) state_d = StLaunch;
      end
      StHold: begin
        if (cnt_q >= HoldLast) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
    end
  end

  // cs_n decoded from state so reset raises it without waiting for a clock
  assign cs_n       = (state_q == StIdle);
  assign frame_done = frame_done_q;
  assign byte_data  = byte_start ? tx_head[7:0] : 8'h00;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
`ifdef SPI_XFER_RX_FIFO_EN
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [AW:0] rx_wptr_q, rx_wptr_d;
  logic [AW:0] rx_rptr_q, rx_rptr_d;
  logic        rx_empty, rx_full, rx_push, rx_pop;
  logic        rx_ovf_q, rx_ovf_d;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign rx_push  = rx_push_req & (~rx_full | rx_pop);
  assign rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[AW-1:0]];

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_ovf_d  = rx_ovf_q | (rx_push_req & rx_full & ~rx_pop);
    if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= byte_rx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  assign rx_overflow = rx_ovf_q;
`else
  logic unused_rx;
  assign unused_rx   = ^{byte_rx, rx_ready, rx_push_req};
  assign rx_valid    = 1'b0;
  assign rx_data     = 8'h00;
  assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: directed frames against a simple byte-engine model.
// RX-side expectations are compiled in when SPI_XFER_RX_FIFO_EN is defined.
module tb_spi_xfer_ctrl;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned SETUP_CYC  = 2;
  localparam int unsigned HOLD_CYC   = 2;
  localparam int unsigned ENG_LAT    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       byte_start, byte_busy = 1'b0, byte_done = 1'b0;
  logic [7:0] byte_data, byte_rx = 8'h00;
  logic       cs_n, frame_done, rx_overflow;

  spi_xfer_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .byte_start (byte_start),
    .byte_data  (byte_data),
    .byte_busy  (byte_busy),
    .byte_done  (byte_done),
    .byte_rx    (byte_rx),
    .cs_n       (cs_n),
    .frame_done (frame_done),
    .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int  fall_cyc = 0, done_cyc = 0, frame_cnt = 0, start_cnt = 0;
  bit  first_in_frame = 1'b0, setup_chk = 1'b1, eng_stall = 1'b0;
  logic prev_cs = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Engine response is a fixed function of the launched byte: 0xA5 -> 0x3C
  function automatic logic [7:0] resp(input logic [7:0] d);
    return d ^ 8'h99;
  endfunction

  // Byte engine model: reads at negedge, drives just after posedge
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (byte_start) begin
        d = byte_data;
        @(posedge clk); #1 byte_busy = 1'b1;
        repeat (ENG_LAT) @(posedge clk);
        #1;
        byte_done = 1'b1;
        byte_rx   = resp(d);
        byte_busy = 1'b0;
        @(posedge clk); #1;
        byte_done = 1'b0;
        byte_busy = eng_stall;
      end else begin
        @(posedge clk); #1 byte_busy = eng_stall;
      end
    end
  end

  // Monitor: framing timing and scoreboard pops
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_cs && !cs_n) begin
          fall_cyc       = cyc;
          first_in_frame = 1'b1;
        end
        if (!prev_cs && cs_n) begin
          chk("cs_n rise delay after last byte_done", cyc - done_cyc, HOLD_CYC + 1);
          chk("frame_done at cs_n rise", {31'd0, frame_done}, 32'd1);
        end
        if (frame_done) frame_cnt++;
        if (byte_done) done_cyc = cyc;
        if (byte_start) begin
          start_cnt++;
          chk("cs_n low at byte_start", {31'd0, cs_n}, 32'd0);
          if (first_in_frame && setup_chk)
            chk("cs_n fall to first byte_start", cyc - fall_cyc, SETUP_CYC);
          first_in_frame = 1'b0;
          if (tx_exp.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_start with empty scoreboard: byte_data 0x%0h", byte_data);
          end else begin
            chk("byte_data", {24'd0, byte_data}, {24'd0, tx_exp.pop_front()});
          end
        end
`ifdef SPI_XFER_RX_FIFO_EN
        if (rx_valid && rx_ready) begin
          if (rx_exp.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_valid with empty scoreboard: rx_data 0x%0h", rx_data);
          end else begin
            chk("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
          end
        end
`endif
      end
      prev_cs = cs_n;
    end
  end

  task automatic push(input logic [7:0] d, input logic l, input bit rx_kept);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    tx_exp.push_back(d);
    if (rx_kept) rx_exp.push_back(resp(d));
    forever begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL push timeout: tx_ready got 0, expected 1 for byte 0x%0h", d);
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frame_cnt < target && n < 1000) begin
      step(1);
      n++;
    end
    step(6);
    chk("frame_done count", frame_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0, f0, highs, n;
    // Reset state
    step(2);
    chk("reset cs_n", {31'd0, cs_n}, 32'd1);
    chk("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset byte_start", {31'd0, byte_start}, 32'd0);
    chk("reset byte_data", {24'd0, byte_data}, 32'd0);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset rx_overflow", {31'd0, rx_overflow}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(2);

    // Single-byte frame
    push(8'hA5, 1'b1, 1'b1);
    wait_frames(1);
    chk("tx scoreboard drained (single)", tx_exp.size(), 0);
`ifndef SPI_XFER_RX_FIFO_EN
    chk("rx_valid without RX FIFO", {31'd0, rx_valid}, 32'd0);
    rx_exp.delete();
`endif

    // Three-byte frame
    s0 = start_cnt;
    push(8'h01, 1'b0, 1'b1);
    push(8'h02, 1'b0, 1'b1);
    push(8'h03, 1'b1, 1'b1);
    wait_frames(2);
    chk("byte_start count (three-byte)", start_cnt - s0, 3);
`ifndef SPI_XFER_RX_FIFO_EN
    rx_exp.delete();
`endif

    // TX underrun mid-frame
    s0 = start_cnt;
    push(8'h11, 1'b0, 1'b1);
    step(2);
    highs = 0;
    for (int i = 0; i < 48; i++) begin
      if (cs_n) highs++;
      step(1);
    end
    chk("cs_n high samples during stall", highs, 0);
    chk("byte_start count during stall", start_cnt - s0, 1);
    chk("frame_done during stall", frame_cnt, 2);
    push(8'h22, 1'b1, 1'b1);
    wait_frames(3);
    chk("byte_start count (stall frame)", start_cnt - s0, 2);
`ifndef SPI_XFER_RX_FIFO_EN
    rx_exp.delete();
`endif

    // Engine stalled: fill TX, then overflow RX with a nine-byte frame
    rx_ready  = 1'b0;
    eng_stall = 1'b1;
    setup_chk = 1'b0;
    step(2);
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0, 1'b1);
    chk("tx_ready after 8 pushes, engine stalled", {31'd0, tx_ready}, 32'd0);
    eng_stall = 1'b0;
    push(8'h48, 1'b1, 1'b0);
    wait_frames(4);
    setup_chk = 1'b1;
`ifdef SPI_XFER_RX_FIFO_EN
    chk("rx_overflow after 9th byte", {31'd0, rx_overflow}, 32'd1);
    chk("rx_valid with full RX FIFO", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    n = 0;
    while (rx_exp.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    step(2);
    chk("rx scoreboard drained", rx_exp.size(), 0);
    chk("rx_valid after drain", {31'd0, rx_valid}, 32'd0);
    chk("rx_overflow stays sticky", {31'd0, rx_overflow}, 32'd1);
`else
    rx_ready = 1'b1;
    rx_exp.delete();
    chk("rx_overflow without RX FIFO", {31'd0, rx_overflow}, 32'd0);
    chk("rx_valid without RX FIFO (overflow case)", {31'd0, rx_valid}, 32'd0);
`endif

    // Reset while waiting on the second byte of a four-byte frame
    s0 = start_cnt;
    f0 = frame_cnt;
    push(8'h81, 1'b0, 1'b1);
    push(8'h82, 1'b0, 1'b1);
    push(8'h83, 1'b0, 1'b1);
    push(8'h84, 1'b1, 1'b1);
    n = 0;
    while (start_cnt < s0 + 2 && n < 200) begin
      step(1);
      n++;
    end
    chk("second byte launched before reset", start_cnt - s0, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset cs_n", {31'd0, cs_n}, 32'd1);
    chk("async reset tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("async reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("async reset byte_start", {31'd0, byte_start}, 32'd0);
    tx_exp.delete();
    rx_exp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(20);
    chk("no frame_done after reset abort", frame_cnt, f0);
    chk("cs_n idle after reset abort", {31'd0, cs_n}, 32'd1);
    chk("tx_ready after reset abort", {31'd0, tx_ready}, 32'd1);
    chk("rx_valid after reset abort", {31'd0, rx_valid}, 32'd0);

    // Recovery frame
    push(8'h5A, 1'b1, 1'b1);
    wait_frames(f0 + 1);
    chk("tx scoreboard drained (recovery)", tx_exp.size(), 0);
`ifdef SPI_XFER_RX_FIFO_EN
    chk("rx scoreboard drained (recovery)", rx_exp.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
